// File: rtl/io_write_arbiter_if.sv
// io_write_arbiter_if: requester-side handshake and shared I/O write bus signals
interface io_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 16,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic [NUM_REQ*DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ID_W-1:0]           bus_id;
    logic [DATA_W-1:0]         bus_dout;
    logic                      bus_write;
    logic [NUM_REQ-1:0]        grant;
    logic [IDX_W-1:0]          last_idx;
    logic                      locked;

    modport master (
        output req, req_lock, req_id, req_din,
        input  req_ready, bus_id, bus_dout, bus_write, grant, last_idx, locked
    );

    modport slave (
        input  req, req_lock, req_id, req_din,
        output req_ready, bus_id, bus_dout, bus_write, grant, last_idx, locked
    );
endinterface

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin arbiter with burst lock sharing one registered I/O write bus
module io_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 16,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 2
) (
    input logic clk,
    input logic reset,
    io_write_arbiter_if.slave bus
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   owner, owner_nx, win, cand;
    logic [NUM_REQ-1:0] ready;
    logic               found;
    logic [ID_W-1:0]    id_sel;
    logic [DATA_W-1:0]  din_sel;

    // Pick at most one ready requester: the lock owner while locked, else first pending after last_idx
    always_comb begin
        ready = '0;
        found = 1'b0;
        cand  = '0;
        if (!reset) begin
            if (state == LOCKED) begin
                ready[owner] = bus.req[owner];
            end else begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    cand = IDX_W'((int'(bus.last_idx) + i) % NUM_REQ);
                    if (!found && bus.req[cand]) begin
                        ready[cand] = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    // Encode the winner and select its payload; ready only ever marks a pending requester
    always_comb begin
        win     = '0;
        id_sel  = '0;
        din_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                win     = IDX_W'(i);
                id_sel  = bus.req_id[i*ID_W +: ID_W];
                din_sel = bus.req_din[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.locked    = (state == LOCKED);

    // Lock next state: take lock on a locking transfer, release whenever the owner stops asserting lock
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        if (state == UNLOCKED) begin
            if (|ready && bus.req_lock[win]) begin
                state_nx = LOCKED;
                owner_nx = win;
            end
        end else if (!bus.req_lock[owner]) begin
            state_nx = UNLOCKED;
        end
    end

    // Lock state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // Registered bus: strobe and grant follow the accepted write; id/data hold between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.bus_write <= 1'b0;
            bus.bus_id    <= '0;
            bus.bus_dout  <= '0;
            bus.grant     <= '0;
            bus.last_idx  <= IDX_W'(NUM_REQ - 1);
        end else begin
            bus.bus_write <= |ready;
            bus.grant     <= ready;
            if (|ready) begin
                bus.bus_id   <= id_sel;
                bus.bus_dout <= din_sel;
                bus.last_idx <= win;
            end
        end
    end
endmodule
